// File: rtl/subneg_control.sv
// Sequencing FSM for the SUBNEG one-instruction core, driving one shared req/ack memory port.
// Define SUBNEG_INSTR_CNT_EN to add the saturating 32-bit instr_count output.
module subneg_control #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RESET_PC   = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ack,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  halted
`ifdef SUBNEG_INSTR_CNT_EN
    ,
    output logic [31:0]           instr_count
`endif
);

    typedef enum logic [2:0] {
        IDLE, FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE, HALTED
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   reg_a, reg_b, reg_c;
    logic [WIDTH-1:0]        op_a, op_b;

    logic [ADDR_WIDTH-1:0]   pc_next, addr_next, a_next, b_next, c_next;
    logic [WIDTH-1:0]        wdata_next, op_a_next, op_b_next;
    logic                    req_next, we_next;

    logic                    done;
    logic [ADDR_WIDTH-1:0]   rdata_addr;
    logic [WIDTH-1:0]        res;
    logic [ADDR_WIDTH-1:0]   branch_pc;

    assign done       = mem_req && mem_ack;
    assign rdata_addr = ADDR_WIDTH'(mem_rdata);
    assign res        = op_b - op_a;
    assign branch_pc  = res[WIDTH-1] ? reg_c : pc + ADDR_WIDTH'(3);
    assign busy       = (state != IDLE) && (state != HALTED);
    assign halted     = (state == HALTED);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        req_next   = mem_req;
        we_next    = mem_we;
        addr_next  = mem_addr;
        wdata_next = mem_wdata;
        a_next     = reg_a;
        b_next     = reg_b;
        c_next     = reg_c;
        op_a_next  = op_a;
        op_b_next  = op_b;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_next = FETCH_A;
                    pc_next    = PC_INIT;
                    req_next   = 1'b1;
                    we_next    = 1'b0;
                    addr_next  = PC_INIT;
                end
            end
            FETCH_A: if (done) begin
                a_next     = rdata_addr;
                state_next = FETCH_B;
                addr_next  = pc + ADDR_WIDTH'(1);
            end
            FETCH_B: if (done) begin
                b_next     = rdata_addr;
                state_next = FETCH_C;
                addr_next  = pc + ADDR_WIDTH'(2);
            end
            FETCH_C: if (done) begin
                c_next     = rdata_addr;
                state_next = READ_A;
                addr_next  = reg_a;
            end
            READ_A: if (done) begin
                op_a_next  = mem_rdata;
                state_next = READ_B;
                addr_next  = reg_b;
            end
            READ_B: if (done) begin
                // Result goes straight into the write-data register so WRITE presents it at once.
                op_b_next  = mem_rdata;
                state_next = WRITE;
                we_next    = 1'b1;
                addr_next  = reg_b;
                wdata_next = mem_rdata - op_a;
            end
            WRITE: if (done) begin
                we_next = 1'b0;
                if (branch_pc == pc) begin
                    state_next = HALTED;
                    req_next   = 1'b0;
                end else begin
                    state_next = FETCH_A;
                    pc_next    = branch_pc;
                    addr_next  = branch_pc;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
                we_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pc        <= PC_INIT;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            reg_a     <= '0;
            reg_b     <= '0;
            reg_c     <= '0;
            op_a      <= '0;
            op_b      <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            mem_req   <= req_next;
            mem_we    <= we_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
            reg_a     <= a_next;
            reg_b     <= b_next;
            reg_c     <= c_next;
            op_a      <= op_a_next;
            op_b      <= op_b_next;
        end
    end

`ifdef SUBNEG_INSTR_CNT_EN
    logic count_clear, count_inc;

    assign count_clear = start && ((state == IDLE) || (state == HALTED));
    assign count_inc   = (state == WRITE) && done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_count <= '0;
        end else if (count_clear) begin
            instr_count <= '0;
        end else if (count_inc && (instr_count != 32'hFFFF_FFFF)) begin
            instr_count <= instr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_subneg_control.sv
// Directed bench for subneg_control: two instances (RESET_PC 0 and 254) share a modelled memory port.
// Honours SUBNEG_INSTR_CNT_EN to check instr_count when that build is selected.
module tb_subneg_control;

    logic        clock = 1'b0;
    logic        rst1, rst2, start1, start2, sel;
    logic        req1, we1, busy1, halted1;
    logic        req2, we2, busy2, halted2;
    logic [7:0]  addr1, wdata1, pc1, addr2, wdata2, pc2;
    logic [7:0]  rdata;
    logic        ack;
`ifdef SUBNEG_INSTR_CNT_EN
    logic [31:0] cnt1, cnt2;
`endif

    logic        bus_req, bus_we;
    logic [7:0]  bus_addr, bus_wdata;

    logic [7:0]  mem [256];
    logic        clear_en, load_en, hold_ack;
    logic [7:0]  load_addr, load_data;
    int          stall, wait_cnt, write_count;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    subneg_control #(.WIDTH(8), .ADDR_WIDTH(8), .RESET_PC(0)) dut (
        .clock(clock), .reset_n(rst1), .start(start1),
        .mem_req(req1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
        .mem_rdata(rdata), .mem_ack(ack),
        .pc(pc1), .busy(busy1), .halted(halted1)
`ifdef SUBNEG_INSTR_CNT_EN
        , .instr_count(cnt1)
`endif
    );

    subneg_control #(.WIDTH(8), .ADDR_WIDTH(8), .RESET_PC(254)) dut_wrap (
        .clock(clock), .reset_n(rst2), .start(start2),
        .mem_req(req2), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
        .mem_rdata(rdata), .mem_ack(ack),
        .pc(pc2), .busy(busy2), .halted(halted2)
`ifdef SUBNEG_INSTR_CNT_EN
        , .instr_count(cnt2)
`endif
    );

    assign bus_req   = sel ? req2   : req1;
    assign bus_we    = sel ? we2    : we1;
    assign bus_addr  = sel ? addr2  : addr1;
    assign bus_wdata = sel ? wdata2 : wdata1;
    assign rdata     = mem[bus_addr];
    assign ack       = !hold_ack && (wait_cnt >= stall);

    // Memory model: single port, ack after 'stall' wait cycles, plus a bench-side load path.
    always @(posedge clock) begin
        if (clear_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (load_en) begin
            mem[load_addr] <= load_data;
        end
        if (bus_req && bus_we && ack) begin
            mem[bus_addr] <= bus_wdata;
            write_count   <= write_count + 1;
        end
        if (!bus_req || ack) wait_cnt <= 0;
        else                 wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        @(negedge clock);
        load_en   = 1'b0;
    endtask

    task automatic clear_mem();
        clear_en = 1'b1;
        @(negedge clock);
        clear_en = 1'b0;
    endtask

    task automatic setup_instr(input logic [7:0] base, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] va, input logic [7:0] vb);
        clear_mem();
        load(base, a);
        load(base + 8'd1, b);
        load(base + 8'd2, c);
        load(a, va);
        load(b, vb);
    endtask

    task automatic pulse_start1();
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
    endtask

    // One instruction {10,11,9} from pc 0 with ack tied high; ends with dut held in reset.
    task automatic run_one(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input logic [7:0] exp_res, input logic [7:0] exp_pc);
        rst1 = 1'b0;
        setup_instr(8'd0, 8'd10, 8'd11, 8'd9, va, vb);
        rst1 = 1'b1;
        @(negedge clock);
        pulse_start1();
        repeat (5) @(negedge clock);
        check({tag, ".write_we"},    {31'd0, we1}, 32'd1);
        check({tag, ".write_addr"},  {24'd0, addr1}, 32'd11);
        check({tag, ".write_data"},  {24'd0, wdata1}, {24'd0, exp_res});
        check({tag, ".not_yet"},     {24'd0, mem[11]}, {24'd0, vb});
        @(negedge clock);
        check({tag, ".mem11"},       {24'd0, mem[11]}, {24'd0, exp_res});
        check({tag, ".pc"},          {24'd0, pc1}, {24'd0, exp_pc});
        check({tag, ".busy"},        {31'd0, busy1}, 32'd1);
        check({tag, ".next_fetch"},  {24'd0, addr1}, {24'd0, exp_pc});
        rst1 = 1'b0;
    endtask

    logic [7:0] exp_addr [6];
    logic       exp_we   [6];
    int         wc_before;

    initial begin
        rst1 = 1'b0; rst2 = 1'b0; start1 = 1'b0; start2 = 1'b0; sel = 1'b0;
        clear_en = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        hold_ack = 1'b0; stall = 0; wait_cnt = 0; write_count = 0;

        #12;
        check("reset.req",    {31'd0, req1}, 32'd0);
        check("reset.we",     {31'd0, we1}, 32'd0);
        check("reset.addr",   {24'd0, addr1}, 32'd0);
        check("reset.wdata",  {24'd0, wdata1}, 32'd0);
        check("reset.pc",     {24'd0, pc1}, 32'd0);
        check("reset.busy",   {31'd0, busy1}, 32'd0);
        check("reset.halted", {31'd0, halted1}, 32'd0);
        check("reset.pc_wrap_inst", {24'd0, pc2}, 32'd254);
        @(negedge clock);

        // 3-5 = -2 branches to C; 7-2 = 5 falls through; 0x80-1 wraps to 0x7F and falls through.
        run_one("neg",  8'd5, 8'd3,    8'hFE, 8'd9);
        run_one("pos",  8'd2, 8'd7,    8'h05, 8'd3);
        run_one("wrap", 8'd1, 8'h80,   8'h7F, 8'd3);

        // Halt: C equals the current pc and the result is negative.
        setup_instr(8'd0, 8'd20, 8'd21, 8'd0, 8'd1, 8'd0);
        rst1 = 1'b1;
        @(negedge clock);
        pulse_start1();
        repeat (6) @(negedge clock);
        check("halt.mem21",  {24'd0, mem[21]}, 32'hFF);
        check("halt.halted", {31'd0, halted1}, 32'd1);
        check("halt.busy",   {31'd0, busy1}, 32'd0);
        check("halt.pc",     {24'd0, pc1}, 32'd0);
        check("halt.req",    {31'd0, req1}, 32'd0);
`ifdef SUBNEG_INSTR_CNT_EN
        check("halt.count",  cnt1, 32'd1);
`endif
        pulse_start1();
        check("restart.busy",   {31'd0, busy1}, 32'd1);
        check("restart.halted", {31'd0, halted1}, 32'd0);
        check("restart.req",    {31'd0, req1}, 32'd1);
        check("restart.addr",   {24'd0, addr1}, 32'd0);
`ifdef SUBNEG_INSTR_CNT_EN
        check("restart.count",  cnt1, 32'd0);
`endif
        repeat (6) @(negedge clock);
        check("rehalt.mem21",  {24'd0, mem[21]}, 32'hFE);
        check("rehalt.halted", {31'd0, halted1}, 32'd1);
`ifdef SUBNEG_INSTR_CNT_EN
        check("rehalt.count",  cnt1, 32'd1);
`endif
        rst1 = 1'b0;

        // Stalled accesses from RESET_PC 254: fetches wrap 254, 255, 0 and pc wraps to 1.
        sel   = 1'b1;
        stall = 3;
        setup_instr(8'd254, 8'd10, 8'd11, 8'd100, 8'd2, 8'd7);
        rst2 = 1'b1;
        @(negedge clock);
        start2 = 1'b1;
        @(negedge clock);
        start2 = 1'b0;
        exp_addr = '{8'd254, 8'd255, 8'd0, 8'd10, 8'd11, 8'd11};
        exp_we   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            for (int s = 0; s < 4; s++) begin
                check($sformatf("stall.req[%0d.%0d]", k, s),  {31'd0, req2}, 32'd1);
                check($sformatf("stall.addr[%0d.%0d]", k, s), {24'd0, addr2}, {24'd0, exp_addr[k]});
                check($sformatf("stall.we[%0d.%0d]", k, s),   {31'd0, we2}, {31'd0, exp_we[k]});
                @(negedge clock);
            end
        end
        check("stall.pc",    {24'd0, pc2}, 32'd1);
        check("stall.mem11", {24'd0, mem[11]}, 32'd5);
        check("stall.busy",  {31'd0, busy2}, 32'd1);
        rst2  = 1'b0;
        sel   = 1'b0;
        stall = 0;

        // Reset during a stalled READ_B must drop the request at once and never write.
        setup_instr(8'd0, 8'd10, 8'd11, 8'd9, 8'd5, 8'd3);
        rst1 = 1'b1;
        @(negedge clock);
        pulse_start1();
        repeat (4) @(negedge clock);
        hold_ack = 1'b1;
        check("midrst.readb_addr", {24'd0, addr1}, 32'd11);
        check("midrst.readb_req",  {31'd0, req1}, 32'd1);
        check("midrst.readb_we",   {31'd0, we1}, 32'd0);
        repeat (2) @(negedge clock);
        check("midrst.held_addr",  {24'd0, addr1}, 32'd11);
        check("midrst.held_req",   {31'd0, req1}, 32'd1);
        #2 rst1 = 1'b0;
        #1;
        check("midrst.req",    {31'd0, req1}, 32'd0);
        check("midrst.pc",     {24'd0, pc1}, 32'd0);
        check("midrst.busy",   {31'd0, busy1}, 32'd0);
        check("midrst.halted", {31'd0, halted1}, 32'd0);
        wc_before = write_count;
        @(negedge clock);
        rst1     = 1'b1;
        hold_ack = 1'b0;
        repeat (10) @(negedge clock);
        check("midrst.mem11",   {24'd0, mem[11]}, 32'd3);
        check("midrst.nowrite", write_count, wc_before);
        check("midrst.idle_req", {31'd0, req1}, 32'd0);
        check("midrst.idle_busy", {31'd0, busy1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/subneg_control.md
Name: subneg_control

Overview:
- Sequencing FSM for the SUBNEG one-instruction core.
- Fetches the three-word instruction (A, B, C) and reads mem[A] and mem[B].
- Computes mem[B] - mem[A], writes the result to mem[B], then sets PC to C if the result is negative, else to PC+3.
- Sits between the PC/increment datapath and a single shared memory port with a req/ack handshake.

Parameters:
- WIDTH, 8, data word width (signed two's complement).
- ADDR_WIDTH, 8, memory address width; PC width.
- RESET_PC, 0, PC value loaded on reset and on start.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin execution at RESET_PC; honoured only in IDLE or HALTED.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_WIDTH  access address.
- mem_wdata  out  WIDTH  write data; valid while mem_req && mem_we.
- mem_rdata  in  WIDTH  read data; valid in the ack cycle of a read.
- mem_ack  in  1  access completes in any cycle where mem_req && mem_ack.
- pc  out  ADDR_WIDTH  current instruction address.
- busy  out  1  high in every state except IDLE and HALTED.
- halted  out  1  high in HALTED.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; pc = RESET_PC.
  - mem_req, mem_we, busy and halted = 0; mem_addr and mem_wdata = 0.
  - Internal A/B/C/operand registers cleared.
- States and accesses (each access state advances only on mem_req && mem_ack):
  - IDLE: start -> FETCH_A.
  - FETCH_A: read at pc; latch the address operand A.
  - FETCH_B: read at pc+1; latch B.
  - FETCH_C: read at pc+2; latch C.
  - READ_A: read at A; latch opA.
  - READ_B: read at B; latch opB.
  - WRITE: write res = opB - opA to address B.
  - WRITE completion: compute next_pc. If next_pc == pc, go to HALTED (pc unchanged). Otherwise load pc with next_pc and go to FETCH_A.
  - HALTED: start -> pc = RESET_PC, then FETCH_A.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered.
  - They must be held stable from the first request cycle until the ack cycle.
  - The next access is presented the cycle after ack, so mem_req may stay high across back-to-back accesses.
  - mem_ack outside mem_req is ignored.
- Latency: with mem_ack tied high, 6 cycles per instruction; the first request appears 1 cycle after start is sampled.
- Arithmetic:
  - res is WIDTH bits, modulo 2^WIDTH; overflow wraps, no flag.
  - Negative means res[WIDTH-1] = 1.
  - next_pc = res negative ? C : pc + 3.
- Address rules:
  - Operand words are converted to addresses by taking the low ADDR_WIDTH bits, zero-extended if WIDTH < ADDR_WIDTH.
  - pc+1, pc+2 and pc+3 wrap modulo 2^ADDR_WIDTH.
- start while busy: ignored.
- Reset mid-access: mem_req drops asynchronously; no partial write may be retried.

Optional Feature:
- Macro: SUBNEG_INSTR_CNT_EN.
- Defined:
  - Adds output instr_count, 32 bits.
  - Increments on every WRITE completion, including the one that enters HALTED.
  - Cleared by reset and by an accepted start.
  - Saturates at 0xFFFFFFFF.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Negative branch: ack tied high; mem[0..2]={10,11,9}, mem[10]=5, mem[11]=3; pulse start -> mem[11]=0xFE written on cycle 6; pc=9; busy=1.
- Non-negative fall-through: same setup but mem[10]=2, mem[11]=7 -> mem[11]=5; pc=3.
- Overflow wrap: mem[10]=1, mem[11]=0x80 -> mem[11]=0x7F (non-negative); pc=3.
- Halt: mem[0..2]={20,21,0}, mem[20]=1, mem[21]=0 -> mem[21]=0xFF; halted=1, busy=0, pc=0, mem_req=0. A further start restarts at 0; with the counter feature enabled, instr_count=1 at the halt.
- Ack stall and PC wrap: RESET_PC=254; mem_ack held low 3 cycles per access.
  - mem_req, mem_addr and mem_we stay stable through each stall.
  - Fetch addresses are 254, 255, 0.
  - The non-negative result gives pc=1.
- Reset mid-operation: assert reset_n=0 during READ_B with ack low.
  - mem_req goes low immediately; pc=RESET_PC; state IDLE.
  - No write occurs after release until a new start.
